tracklet_div_31s_16ns_18s: RTL and testbench

- Sequential signed divider; the inverse of the 16ns x 18s -> 31s product multiplier used in the TrackletCalculator datapath.
- Takes a signed 31-bit product-domain value and an unsigned 16-bit divisor, and returns a signed 18-bit saturated quotient plus remainder.
- Used where the calculator must recover a coefficient from a product, e.g. residual normalisation.
- Iterative restoring division with valid/ready handshakes on both sides; one operation in flight at a time.

---
 rtl/tracklet_div_31s_16ns_18s.sv | 203 ++++++++++++++++++++
 tb/tb_tracklet_div_31s_16ns_18s.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tracklet_div_31s_16ns_18s.sv
// -----------------------------------------------------------------------------
// tracklet_div_31s_16ns_18s
//
// Sequential signed divider: recovers an 18-bit signed coefficient from a
// 31-bit signed product-domain value and a 16-bit unsigned divisor. It is the
// inverse of the 16ns x 18s -> 31s multiplier in the tracklet datapath.
// Restoring division on the dividend magnitude, one quotient bit per cycle,
// MSB first. The sign is applied afterwards, then the quotient is saturated.
//
// Optional build macro: TC_DIV_ROUND_EN
//   defined   : the quotient magnitude is rounded to nearest, ties away from
//               zero, before sign and saturation. rem stays truncated.
//   undefined : pure truncation toward zero.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (IDLE only)
//   din0       in   signed dividend   [DIVIDEND_W-1:0]
//   din1       in   unsigned divisor  [DIVISOR_W-1:0]
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   dout       out  signed saturated quotient [QUOT_W-1:0]
//   rem        out  signed remainder, sign of dividend [DIVISOR_W:0]
//   ovf        out  quotient saturated (also set on divide by zero)
//   dz         out  divide by zero
// -----------------------------------------------------------------------------
module tracklet_div_31s_16ns_18s #(
    parameter int DIVIDEND_W = 31,
    parameter int DIVISOR_W  = 16,
    parameter int QUOT_W     = 18
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     dout,
    output logic [DIVISOR_W:0]    rem,
    output logic                  ovf,
    output logic                  dz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    // Saturation limits expressed as magnitudes, in the widened magnitude
    // domain (one extra bit so a rounding carry cannot wrap).
    localparam logic [DIVIDEND_W:0] POS_LIM = (DIVIDEND_W+1)'((1 << (QUOT_W-1)) - 1);
    localparam logic [DIVIDEND_W:0] NEG_LIM = (DIVIDEND_W+1)'(1 << (QUOT_W-1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [DIVIDEND_W-1:0]   dvd_reg;      // dividend magnitude, shifted out MSB first
    logic [DIVISOR_W-1:0]    dsr_reg;
    logic                    neg_reg;      // sign of the dividend
    logic [DIVISOR_W:0]      prem_reg;     // partial remainder
    logic [DIVIDEND_W-1:0]   quo_reg;      // quotient magnitude
    logic [CNT_W-1:0]        cnt_reg;
    logic                    in_ready_reg;
    logic [QUOT_W-1:0]       dout_reg;
    logic [DIVISOR_W:0]      rem_reg;
    logic                    ovf_reg;
    logic                    dz_reg;

    logic                    accept;
    logic                    last_iter;
    logic [DIVIDEND_W-1:0]   din_mag;
    logic [DIVISOR_W:0]      prem_shift;
    logic [DIVISOR_W:0]      prem_sub;
    logic                    prem_ge;
    logic                    round_inc;
    logic [DIVIDEND_W:0]     mag_q;
    logic                    clip;
    logic [QUOT_W-1:0]       sat_mag;
    logic [QUOT_W-1:0]       dout_fin;
    logic [DIVISOR_W:0]      rem_fin;
    logic                    dz_fin;

    // in_ready_reg is only ever high while the FSM sits in IDLE.
    assign accept    = in_valid && in_ready_reg;
    assign last_iter = (cnt_reg == CNT_W'(DIVIDEND_W-1));

    // Two's-complement magnitude; the most negative dividend maps to 2^30,
    // which still fits as an unsigned DIVIDEND_W-bit value.
    assign din_mag = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;

    // The partial remainder is always below the divisor, so its top bit is
    // zero and can be dropped when shifting the next dividend bit in.
    assign prem_shift = {prem_reg[DIVISOR_W-1:0], dvd_reg[DIVIDEND_W-1]};
    assign prem_ge    = (prem_shift >= {1'b0, dsr_reg});
    assign prem_sub   = prem_shift - {1'b0, dsr_reg};

`ifdef TC_DIV_ROUND_EN
    // Ties away from zero: bump the magnitude when 2*r >= d.
    assign round_inc = ({prem_reg, 1'b0} >= {2'b00, dsr_reg});
`else
    assign round_inc = 1'b0;
`endif

    // Result formation for FIN.
    always_comb begin
        mag_q    = {1'b0, quo_reg} + (DIVIDEND_W+1)'(round_inc);
        clip     = 1'b0;
        sat_mag  = mag_q[QUOT_W-1:0];
        dz_fin   = (dsr_reg == '0);
        if (neg_reg) begin
            if (mag_q > NEG_LIM) begin
                clip    = 1'b1;
                sat_mag = NEG_LIM[QUOT_W-1:0];
            end
        end else begin
            if (mag_q > POS_LIM) begin
                clip    = 1'b1;
                sat_mag = POS_LIM[QUOT_W-1:0];
            end
        end
        dout_fin = neg_reg ? (~sat_mag + 1'b1) : sat_mag;
        rem_fin  = neg_reg ? (~prem_reg + 1'b1) : prem_reg;
        if (dz_fin) begin
            // Divide by zero: saturate in the direction of the dividend.
            clip     = 1'b1;
            dout_fin = neg_reg ? NEG_LIM[QUOT_W-1:0] : POS_LIM[QUOT_W-1:0];
            rem_fin  = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (last_iter) state_next = FIN;
            FIN:                    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
            dvd_reg      <= '0;
            dsr_reg      <= '0;
            neg_reg      <= 1'b0;
            prem_reg     <= '0;
            quo_reg      <= '0;
            cnt_reg      <= '0;
            dout_reg     <= '0;
            rem_reg      <= '0;
            ovf_reg      <= 1'b0;
            dz_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            // Registered so that in_ready stays low for the first edge after
            // reset release, then tracks IDLE exactly.
            in_ready_reg <= (state_next == IDLE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dvd_reg  <= din_mag;
                        dsr_reg  <= din1;
                        neg_reg  <= din0[DIVIDEND_W-1];
                        prem_reg <= '0;
                        quo_reg  <= '0;
                        cnt_reg  <= '0;
                    end
                end
                CALC: begin
                    prem_reg <= prem_ge ? prem_sub : prem_shift;
                    quo_reg  <= {quo_reg[DIVIDEND_W-2:0], prem_ge};
                    dvd_reg  <= {dvd_reg[DIVIDEND_W-2:0], 1'b0};
                    cnt_reg  <= cnt_reg + 1'b1;
                end
                FIN: begin
                    dout_reg <= dout_fin;
                    rem_reg  <= rem_fin;
                    ovf_reg  <= clip;
                    dz_reg   <= dz_fin;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == DONE);
    assign dout      = dout_reg;
    assign rem       = rem_reg;
    assign ovf       = ovf_reg;
    assign dz        = dz_reg;

endmodule

// File: tb/tb_tracklet_div_31s_16ns_18s.sv
// -----------------------------------------------------------------------------
// Testbench for tracklet_div_31s_16ns_18s: directed vector table, backpressure
// and mid-operation reset sequences, then randomized operands against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_tracklet_div_31s_16ns_18s;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] din0 = '0;
    logic [15:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] dout;
    logic [16:0] rem;
    logic        ovf;
    logic        dz;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    tracklet_div_31s_16ns_18s dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .rem      (rem),
        .ovf      (ovf),
        .dz       (dz)
    );

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint r;
        longint o;
        longint z;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division on magnitudes, then sign and clip.
    task automatic model(input longint a, input longint b,
                         output longint q, output longint r,
                         output longint o, output longint z);
        longint mag, qm, rm, sq;
        mag = (a < 0) ? -a : a;
        if (b == 0) begin
            z = 1; o = 1; r = 0;
            q = (a < 0) ? -131072 : 131071;
        end else begin
            z = 0;
            qm = mag / b;
            rm = mag % b;
`ifdef TC_DIV_ROUND_EN
            if (2 * rm >= b) qm = qm + 1;
`endif
            sq = (a < 0) ? -qm : qm;
            o = 0;
            if (sq > 131071)  begin sq = 131071;  o = 1; end
            if (sq < -131072) begin sq = -131072; o = 1; end
            q = sq;
            r = (a < 0) ? -rm : rm;
        end
    endtask

    // Issue one operation and collect its result; lat counts rising edges
    // from the accepting edge to the first cycle with out_valid high.
    task automatic run_op(input longint a, input longint b,
                          output longint q, output longint r,
                          output longint o, output longint z,
                          output longint lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        din0 = 31'(a);
        din1 = 16'(b);
        in_valid = 1'b1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        din0 = 31'($urandom);   // must be ignored while busy
        din1 = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge ap_clk);
            lat++;
        end
        q = longint'($signed(dout));
        r = longint'($signed(rem));
        o = longint'(ovf);
        z = longint'(dz);
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string tag, input longint a, input longint b,
                            input longint eq, input longint er,
                            input longint eo, input longint ez);
        longint q, r, o, z, lat;
        run_op(a, b, q, r, o, z, lat);
        $display("op %s: %0d / %0d -> dout=%0d rem=%0d ovf=%0d dz=%0d lat=%0d",
                 tag, a, b, q, r, o, z, lat);
        check({tag, ".lat"}, lat, 32);
        check({tag, ".dout"}, q, eq);
        check({tag, ".rem"}, r, er);
        check({tag, ".ovf"}, o, eo);
        check({tag, ".dz"}, z, ez);
        check({tag, ".valid_drop"}, longint'(out_valid), 0);
    endtask

    initial begin
        vec_t   vecs[$];
        longint q, r, o, z, lat;
        longint hq, hr, ho, hz;
        bit     stable;
        logic signed [30:0] r31;
        longint ra, rb;

`ifdef TC_DIV_ROUND_EN
        vecs.push_back('{1000, 7, 143, 6, 0, 0});
        vecs.push_back('{-1000, 7, -143, -6, 0, 0});
`else
        vecs.push_back('{1000, 7, 142, 6, 0, 0});
        vecs.push_back('{-1000, 7, -142, -6, 0, 0});
`endif
        vecs.push_back('{536870912, 1, 131071, 0, 1, 0});
        vecs.push_back('{-1073741824, 1, -131072, 0, 1, 0});
        vecs.push_back('{131072, 1, 131071, 0, 1, 0});
        vecs.push_back('{131071, 1, 131071, 0, 0, 0});
        vecs.push_back('{-131072, 1, -131072, 0, 0, 0});
        vecs.push_back('{-131073, 1, -131072, 0, 1, 0});
        vecs.push_back('{500, 0, 131071, 0, 1, 1});
        vecs.push_back('{-5, 0, -131072, 0, 1, 1});
        vecs.push_back('{0, 9, 0, 0, 0, 0});
        vecs.push_back('{100, 3, 33, 1, 0, 0});
        vecs.push_back('{1073741823, 65535, 16384, 16383, 0, 0});

        // Reset state.
        repeat (3) @(negedge ap_clk);
        check("rst.in_ready", longint'(in_ready), 0);
        check("rst.out_valid", longint'(out_valid), 0);
        check("rst.dout", longint'(dout), 0);
        check("rst.rem", longint'(rem), 0);
        check("rst.ovf", longint'(ovf), 0);
        check("rst.dz", longint'(dz), 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("rst.in_ready_release", longint'(in_ready), 1);

        // Directed table.
        foreach (vecs[i])
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                     vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z);

        // Backpressure: result held for 10 cycles while new operands wave
        // about; the pending in_valid is taken only after the handshake.
        din0 = 31'(1000); din1 = 16'(7); in_valid = 1'b1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge ap_clk); lat++; end
        check("bp.lat", lat, 32);
        hq = longint'($signed(dout)); hr = longint'($signed(rem));
        ho = longint'(ovf); hz = longint'(dz);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            din0 = 31'(100); din1 = 16'(3); in_valid = c[0];
            @(negedge ap_clk);
            if (!out_valid || in_ready ||
                longint'($signed(dout)) != hq || longint'($signed(rem)) != hr ||
                longint'(ovf) != ho || longint'(dz) != hz)
                stable = 1'b0;
        end
        check("bp.stable", longint'(stable), 1);
`ifdef TC_DIV_ROUND_EN
        check("bp.dout", hq, 143);
`else
        check("bp.dout", hq, 142);
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        check("bp.no_overlap_valid", longint'(out_valid), 0);
        check("bp.no_overlap_ready", longint'(in_ready), 1);
        @(negedge ap_clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge ap_clk); lat++; end
        $display("op bp_next: 100 / 3 -> dout=%0d rem=%0d lat=%0d",
                 $signed(dout), $signed(rem), lat);
        check("bp_next.lat", lat, 32);
        check("bp_next.dout", longint'($signed(dout)), 33);
        check("bp_next.rem", longint'($signed(rem)), 1);
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;

        // Reset in the middle of CALC aborts the operation.
        din0 = 31'(1000); din1 = 16'(7); in_valid = 1'b1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (15) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("midrst.out_valid", longint'(out_valid), 0);
        check("midrst.in_ready", longint'(in_ready), 0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("midrst.in_ready_release", longint'(in_ready), 1);
        check("midrst.no_result", longint'(out_valid), 0);
        check_op("midrst_next", 100, 3, 33, 1, 0, 0);

        // Randomized operands against the model.
        for (int i = 0; i < 60; i++) begin
            r31 = 31'($urandom);
            ra = longint'(r31);
            if ($urandom_range(0, 1) == 1) ra = longint'($urandom_range(0, 400000)) - 200000;
            case ($urandom_range(0, 9))
                0:       rb = 0;
                1, 2, 3: rb = longint'($urandom_range(1, 16));
                default: rb = longint'($urandom_range(1, 65535));
            endcase
            model(ra, rb, q, r, o, z);
            check_op($sformatf("rnd%0d", i), ra, rb, q, r, o, z);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
